// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store sequencer in front of a word-wide main memory;
//            sub-word stores are done as read-modify-write.
// Revision : 1.0
// ============================================================================
module load_store_unit #(
    parameter logic [31:0] ADDR_BASE = 32'h0100_0000,
    parameter logic [31:0] ADDR_SPAN = 32'h0010_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output logic        mem_read_write
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_t;

    // 33-bit bounds so that a region ending at 4 GiB does not wrap.
    localparam logic [32:0] c_addr_lo = {1'b0, ADDR_BASE};
    localparam logic [32:0] c_addr_hi = {1'b0, ADDR_BASE} + {1'b0, ADDR_SPAN};

    state_t      r_state;
    logic [1:0]  r_lane;
    logic [2:0]  r_funct3;
    logic [15:0] r_wdata;
    logic        r_mem_we;

    logic        w_legal;
    logic        w_misaligned;
    logic        w_in_range;
    logic        w_fault;
    logic [31:0] w_req_word_addr;
    logic [4:0]  w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_mask;
    logic [31:0] w_merged;

    // Request screening happens on the incoming request, before it is registered.
    assign w_legal = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                               : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                          ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_in_range   = ({1'b0, req_addr} >= c_addr_lo) && ({1'b0, req_addr} < c_addr_hi);
    assign w_fault      = !w_legal || w_misaligned || !w_in_range;
    assign w_req_word_addr = {req_addr[31:2], 2'b00};

    // Halfwords are 2-byte aligned, so the byte-lane shift also selects the half lane.
    assign w_shift = {r_lane, 3'b000};
    assign w_byte  = 8'(mem_data_out >> w_shift);
    assign w_half  = 16'(mem_data_out >> w_shift);

    always_comb begin
        w_load_data = mem_data_out;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'b0, w_byte};
            3'b101:  w_load_data = {16'b0, w_half};
            default: w_load_data = mem_data_out;
        endcase
    end

    assign w_mask   = (r_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_shift;
    assign w_merged = (mem_data_out & ~w_mask) | (({16'b0, r_wdata} << w_shift) & w_mask);

    assign req_ready      = (r_state == IDLE);
    assign mem_read_write = r_mem_we & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= IDLE;
            r_lane      <= 2'b00;
            r_funct3    <= 3'b000;
            r_wdata     <= 16'b0;
            r_mem_we    <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'b0;
            resp_fault  <= 1'b0;
            mem_address <= 32'b0;
            mem_data_in <= 32'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_lane   <= req_addr[1:0];
                        r_funct3 <= req_funct3;
                        r_wdata  <= req_wdata[15:0];
                        if (w_fault) begin
                            r_state    <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'b0;
                        end else if (!req_write) begin
                            r_state     <= LOAD;
                            mem_address <= w_req_word_addr;
                        end else if (req_funct3 == 3'b010) begin
                            r_state     <= WRITE;
                            mem_address <= w_req_word_addr;
                            mem_data_in <= req_wdata;
                            r_mem_we    <= 1'b1;
                        end else begin
                            r_state     <= RMW_READ;
                            mem_address <= w_req_word_addr;
                        end
                    end
                end
                LOAD: begin
                    r_state     <= RESP;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= w_load_data;
                    resp_fault  <= 1'b0;
                    mem_address <= 32'b0;
                end
                RMW_READ: begin
                    r_state     <= WRITE;
                    mem_data_in <= w_merged;
                    r_mem_we    <= 1'b1;
                end
                WRITE: begin
                    r_state     <= RESP;
                    r_mem_we    <= 1'b0;
                    mem_data_in <= 32'b0;
                    mem_address <= 32'b0;
                    resp_valid  <= 1'b1;
                    resp_rdata  <= 32'b0;
                    resp_fault  <= 1'b0;
                end
                RESP: begin
                    r_state    <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Scoreboard bench for load_store_unit with a word memory model.
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] SPAN = 32'h0010_0000;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_read_write;

    load_store_unit #(.ADDR_BASE(BASE), .ADDR_SPAN(SPAN)) dut (
        .clock          (clock),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_fault     (resp_fault),
        .mem_address    (mem_address),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .mem_read_write (mem_read_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [31:0] rdata; logic fault; int cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;

    resp_t resp_q[$];
    wr_t   wr_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    cyc      = 0;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Main memory model: first 1 KiB of the region, combinational read.
    logic [31:0] mem [0:255];
    logic        mem_init;
    assign mem_data_out = mem[mem_address[9:2]];
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_read_write) begin
            mem[mem_address[9:2]] <= mem_data_in;
        end
    end

    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] ref_mem [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: derives the architectural result of a request from the ISA rules.
    task automatic model(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int acc);
        resp_t       r;
        wr_t         w;
        longint      la;
        int          size;
        int          sh;
        int          idx;
        bit          fault;
        logic [31:0] word;
        logic [31:0] mask;
        la    = longint'(a);
        size  = 1 << f3[1:0];
        fault = wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((a % 32'(size)) != 0) fault = 1'b1;
        if (la < longint'(BASE) || la >= longint'(BASE) + longint'(SPAN)) fault = 1'b1;
        r.fault = fault;
        r.rdata = 32'h0;
        if (fault) begin
            r.cyc = acc + 1;
        end else begin
            idx  = int'((a - BASE) >> 2) & 255;
            sh   = int'(a % 4) * 8;
            word = ref_mem[idx];
            if (!wr) begin
                case (f3)
                    3'd0: r.rdata = 32'($signed(8'(word >> sh)));
                    3'd4: r.rdata = 32'(8'(word >> sh));
                    3'd1: r.rdata = 32'($signed(16'(word >> sh)));
                    3'd5: r.rdata = 32'(16'(word >> sh));
                    default: r.rdata = word;
                endcase
                r.cyc = acc + 2;
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1) << sh;
                word = (word & ~mask) | ((wd << sh) & mask);
                ref_mem[idx] = word;
                w.addr = a & ~32'd3;
                w.data = word;
                w.cyc  = acc + ((size == 4) ? 1 : 2);
                wr_q.push_back(w);
                r.cyc = acc + ((size == 4) ? 2 : 3);
            end
        end
        resp_q.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit track);
        int t = 0;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL ready_timeout: got req_ready=0 for 50 cycles, expected 1");
        end else if (track) begin
            model(wr, f3, a, wd, cyc);
        end
        @(negedge clock);
    endtask

    always @(negedge clock) begin : resp_mon
        resp_t e;
        wr_t   w;
        if (resp_valid === 1'b1) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h, expected no response", resp_rdata);
            end else begin
                e = resp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                check("resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_read_write === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got write %h at %h, expected none", mem_data_in, mem_address);
            end else begin
                w = wr_q.pop_front();
                check("wr_addr", mem_address, w.addr);
                check("wr_data", mem_data_in, w.data);
                check("wr_cycle", 32'(cyc), 32'(w.cyc));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected $finish before timeout");
        $fatal(1);
    end

    initial begin : main
        bit          wr;
        logic [2:0]  f3;
        logic [31:0] a;
        reset      = 1'b1;
        mem_init   = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (3) @(negedge clock);
        reset    = 1'b0;
        mem_init = 1'b0;

        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_data_in", mem_data_in, 32'd0);
        check("rst_mem_rw", {31'b0, mem_read_write}, 32'd0);

        // Load extension on a known word.
        issue(1'b1, 3'b010, BASE + 32'h10, 32'h80FF_7F01, 1'b1);
        issue(1'b0, 3'b000, BASE + 32'h13, 32'h0, 1'b1);
        issue(1'b0, 3'b100, BASE + 32'h13, 32'h0, 1'b1);
        issue(1'b0, 3'b001, BASE + 32'h12, 32'h0, 1'b1);
        // Byte store merge, then word store and read-back.
        issue(1'b1, 3'b010, BASE + 32'h20, 32'h1122_3344, 1'b1);
        issue(1'b1, 3'b000, BASE + 32'h21, 32'h0000_00AB, 1'b1);
        issue(1'b1, 3'b010, BASE + 32'h04, 32'hDEAD_BEEF, 1'b1);
        issue(1'b0, 3'b010, BASE + 32'h04, 32'h0, 1'b1);
        // Faulting requests.
        issue(1'b0, 3'b010, BASE + 32'h02, 32'h0, 1'b1);
        issue(1'b1, 3'b001, BASE + 32'h01, 32'h5555, 1'b1);
        issue(1'b0, 3'b011, BASE, 32'h0, 1'b1);
        issue(1'b0, 3'b000, 32'h00FF_FFFF, 32'h0, 1'b1);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        check("directed_drained", 32'(resp_q.size()), 32'd0);

        // Reset lands while an sh is in its write cycle.
        issue(1'b1, 3'b001, BASE + 32'h30, 32'h0000_BEEF, 1'b0);
        req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check("rst_write_gated", {31'b0, mem_read_write}, 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_abort_ready", {31'b0, req_ready}, 32'd1);
        check("rst_abort_no_resp", {31'b0, resp_valid}, 32'd0);
        check("rst_mem_unchanged", mem[12], ref_mem[12]);

        // Randomized traffic with occasional idle gaps.
        for (int i = 0; i < 150; i++) begin
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
            else if (wr) f3 = 3'($urandom_range(0, 2));
            else begin
                f3 = 3'($urandom_range(0, 4));
                if (f3 == 3'd3) f3 = 3'd5;
            end
            a = BASE + 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0)
                a = ($urandom_range(0, 1) != 0) ? BASE - 32'($urandom_range(1, 64))
                                                : BASE + SPAN + 32'($urandom_range(0, 64));
            issue(wr, f3, a, $urandom, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
            end
        end

        // Three loads with req_valid held high throughout.
        issue(1'b0, 3'b010, BASE + 32'h04, 32'h0, 1'b1);
        issue(1'b0, 3'b000, BASE + 32'h11, 32'h0, 1'b1);
        issue(1'b0, 3'b101, BASE + 32'h22, 32'h0, 1'b1);
        req_valid = 1'b0;

        repeat (10) @(negedge clock);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 'h01000000, first byte address of main memory.
REQ-002 SHALL have parameter ADDR_SPAN, default 'h00100000, main memory size in bytes.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core request present.
REQ-006 SHALL have port req_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width/sign code.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data; low bits used for byte and half stores.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load result.
REQ-013 SHALL have port resp_fault  output  1  request rejected; qualified by resp_valid.
REQ-014 SHALL have port mem_address  output  32  word-aligned address to main memory.
REQ-015 SHALL have port mem_data_in  output  32  write word to main memory.
REQ-016 SHALL have port mem_data_out  input  32  combinational read word from main memory.
REQ-017 SHALL have port mem_read_write  output  1  0 = READ, 1 = WRITE; memory writes on the rising edge when 1.

Function
REQ-018 SHALL implement states IDLE, LOAD, RMW_READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-019 SHALL accept a request at edge N when req_valid && req_ready, registering addr, funct3, wdata and write.
REQ-020 SHALL fault (IDLE->RESP, no memory access) on any of:
- load funct3 not in {000,001,010,100,101}, or store funct3 not in {000,001,010};
- halfword with addr[0]=1;
- word with addr[1:0]!=0;
- addr < ADDR_BASE, or addr >= ADDR_BASE+ADDR_SPAN.
REQ-021 SHALL transition IDLE->LOAD for a valid load, IDLE->WRITE for sw, and IDLE->RMW_READ for sb/sh.
REQ-022 SHALL drive mem_address = {addr[31:2],2'b00} in LOAD, RMW_READ and WRITE; mem_address = 0 otherwise.
REQ-023 SHALL drive mem_read_write = 1 only in WRITE, and gate it with !reset; mem_data_in = 0 outside WRITE.
REQ-024 SHALL, in LOAD, capture mem_data_out at the edge and go to RESP.
- Byte lane k = addr[1:0] occupies bits [8k+7:8k]; halfword lane = addr[1].
- lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word unchanged.
REQ-025 SHALL, in RMW_READ, capture mem_data_out, replace the addressed byte or half with req_wdata[7:0] or [15:0], then go to WRITE.
REQ-026 SHALL, in WRITE, present the merged word (req_wdata for sw) for exactly one cycle, then go to RESP.
REQ-027 SHALL, in RESP, assert resp_valid for exactly one cycle, then return to IDLE.
- resp_rdata holds the load result; it is 0 for stores and faults.
- resp_fault = 1 only for faulted requests.
REQ-028 SHALL meet these latencies from the accept cycle N, with resp_valid high in the cycle listed:
- fault: N+1;
- load and sw: N+2;
- sb/sh: N+3.
REQ-029 SHALL ignore req_valid while not in IDLE; the request is not captured and a held request is accepted on return to IDLE.
REQ-030 SHALL hold resp_rdata and resp_fault stable until the next RESP.

Reset
REQ-031 SHALL, on reset, set state IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, mem_address=0, mem_data_in=0 and mem_read_write=0.
REQ-032 SHALL abort any in-flight request when reset is asserted in any state.
- No memory write occurs in a cycle where reset is high, including in WRITE.
- No resp_valid is produced for the aborted request.
REQ-033 SHALL give reset priority over a simultaneous req_valid; the request is not accepted.

Verification
REQ-034 SHALL verify load extension: word 'h80FF7F01 at 'h01000010; lb at 'h01000013 -> resp_rdata 'hFFFFFF80, fault 0, resp_valid at N+2; lbu at the same address -> 'h00000080; lh at 'h01000012 -> 'hFFFF80FF.
REQ-035 SHALL verify sb: sb 'h000000AB to 'h01000021 over word 'h11223344 -> exactly one write of 'h1122AB44 at 'h01000020, resp_valid at N+3.
REQ-036 SHALL verify sw: sw 'hDEADBEEF to 'h01000004 -> single WRITE cycle at N+1, following lw returns 'hDEADBEEF.
REQ-037 SHALL verify faults: lw at 'h01000002, sh at 'h01000001, load funct3 011, and lb at 'h00FFFFFF -> resp_fault 1 at N+1, resp_rdata 0, and mem_read_write never 1.
REQ-038 SHALL verify reset during WRITE of an sh -> mem_read_write 0, memory word unchanged, no resp_valid, req_ready 1 in the next cycle.
REQ-039 SHALL verify back-to-back: req_valid held continuously with three loads -> each accepted only in IDLE, responses in order, no request lost or duplicated.
